// File: rtl/frame_sequencer_if.sv
// Frame-counter register write port and frame clock outputs of the APU frame sequencer.
// master = register/host side, slave = frame_sequencer.
interface frame_sequencer_if;
  logic       cfg_we;
  logic       cfg_mode;
  logic       cfg_irq_inhibit;
  logic       irq_ack;
  logic       qfr_pulse;
  logic       hfr_pulse;
  logic       irq;
  logic [2:0] step;
  logic       mode;

  modport master (
    output cfg_we, cfg_mode, cfg_irq_inhibit, irq_ack,
    input  qfr_pulse, hfr_pulse, irq, step, mode
  );

  modport slave (
    input  cfg_we, cfg_mode, cfg_irq_inhibit, irq_ack,
    output qfr_pulse, hfr_pulse, irq, step, mode
  );
endinterface

// File: rtl/frame_sequencer.sv
// APU frame sequencer: prescaler into step ticks, 4/5-step sequence issuing quarter/half-frame
// strobes and the frame IRQ flag. Register writes reconfigure and restart the sequence.
//
// state | meaning
// ST_S0 | step 0: tick gives Q
// ST_S1 | step 1: tick gives Q+H
// ST_S2 | step 2: tick gives Q
// ST_S3 | step 3: mode 0 tick gives Q+H+IRQ and wraps; mode 1 tick gives nothing
// ST_S4 | step 4: mode 1 only, tick gives Q+H and wraps
module frame_sequencer #(
  parameter int DIV_TERM = 1864
) (
  input logic               clk,
  input logic               rst_n,
  frame_sequencer_if.slave  bus
);

  localparam int PW = $clog2(DIV_TERM + 1);

  typedef enum logic [2:0] {
    ST_S0 = 3'd0,
    ST_S1 = 3'd1,
    ST_S2 = 3'd2,
    ST_S3 = 3'd3,
    ST_S4 = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] prescaler, prescaler_nx;
  logic          mode, mode_nx;
  logic          irq_inhibit, irq_inhibit_nx;
  logic          irq, irq_nx;
  logic          qfr, qfr_nx;
  logic          hfr, hfr_nx;
  logic          tick;
  logic          irq_set;

  assign tick = (prescaler == PW'(DIV_TERM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_S0;
      prescaler   <= '0;
      mode        <= 1'b0;
      irq_inhibit <= 1'b0;
      irq         <= 1'b0;
      qfr         <= 1'b0;
      hfr         <= 1'b0;
    end else begin
      state       <= state_nx;
      prescaler   <= prescaler_nx;
      mode        <= mode_nx;
      irq_inhibit <= irq_inhibit_nx;
      irq         <= irq_nx;
      qfr         <= qfr_nx;
      hfr         <= hfr_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    prescaler_nx   = tick ? '0 : prescaler + PW'(1);
    mode_nx        = mode;
    irq_inhibit_nx = irq_inhibit;
    qfr_nx         = 1'b0;
    hfr_nx         = 1'b0;
    irq_set        = 1'b0;

    // A register write restarts the sequence and swallows any coincident tick.
    if (bus.cfg_we) begin
      prescaler_nx   = '0;
      state_nx       = ST_S0;
      mode_nx        = bus.cfg_mode;
      irq_inhibit_nx = bus.cfg_irq_inhibit;
      qfr_nx         = bus.cfg_mode;
      hfr_nx         = bus.cfg_mode;
    end else if (tick) begin
      case (state)
        ST_S0: begin
          qfr_nx   = 1'b1;
          state_nx = ST_S1;
        end
        ST_S1: begin
          qfr_nx   = 1'b1;
          hfr_nx   = 1'b1;
          state_nx = ST_S2;
        end
        ST_S2: begin
          qfr_nx   = 1'b1;
          state_nx = ST_S3;
        end
        ST_S3: begin
          if (!mode) begin
            qfr_nx   = 1'b1;
            hfr_nx   = 1'b1;
            irq_set  = 1'b1;
            state_nx = ST_S0;
          end else begin
            state_nx = ST_S4;
          end
        end
        ST_S4: begin
          qfr_nx   = 1'b1;
          hfr_nx   = 1'b1;
          state_nx = ST_S0;
        end
        default: state_nx = ST_S0;
      endcase
    end

    // Set beats ack; a write with inhibit beats everything.
    irq_nx = irq;
    if (bus.irq_ack)                       irq_nx = 1'b0;
    if (irq_set && !irq_inhibit)           irq_nx = 1'b1;
    if (bus.cfg_we && bus.cfg_irq_inhibit) irq_nx = 1'b0;
  end

  assign bus.qfr_pulse = qfr;
  assign bus.hfr_pulse = hfr;
  assign bus.irq       = irq;
  assign bus.step      = state;
  assign bus.mode      = mode;

endmodule
